// File: rtl/weight_fetch_pkg.sv
// weight_fetch_pkg: SRAM bank widths, controller FSM states and output FIFO entry type
package weight_fetch_pkg;
  localparam int ADDR_W = 9;
  localparam int BN_ADDR_W = 7;
  localparam int BN_W = 16;
  typedef enum logic [2:0] {IDLE, BN_RD, BN_WAIT, W_RD, DRAIN} state_t;
  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } w_entry_t;
endpackage

// File: rtl/weight_fetch_ctrl_if.sv
// weight_fetch_ctrl_if: weight stream to the XNOR-popcount datapath plus SRAM bank read bus
interface weight_fetch_ctrl_if;
  import weight_fetch_pkg::*;
  logic [7:0]           w_data;
  logic                 w_valid;
  logic                 w_ready;
  logic                 w_last;
  logic                 w_cs;
  logic                 w_oe;
  logic [ADDR_W-1:0]    w_addr;
  logic [7:0]           w_rdata;
  logic                 bn_cs;
  logic                 bn_oe;
  logic [BN_ADDR_W-1:0] bn_addr_o;
  logic [BN_W-1:0]      bn_rdata;
  logic [8:0]           sram_we;
  modport master (
    output w_data, w_valid, w_last, w_cs, w_oe, w_addr, bn_cs, bn_oe, bn_addr_o, sram_we,
    input  w_ready, w_rdata, bn_rdata
  );
  modport slave (
    input  w_data, w_valid, w_last, w_cs, w_oe, w_addr, bn_cs, bn_oe, bn_addr_o, sram_we,
    output w_ready, w_rdata, bn_rdata
  );
endinterface

// File: rtl/weight_fetch_fifo.sv
// weight_fetch_fifo: synchronous FIFO of weight entries, extra pointer bit separates full from empty
module weight_fetch_fifo
  import weight_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  logic     pop,
  input  w_entry_t din,
  output w_entry_t dout,
  output logic     full,
  output logic     empty
);
  localparam int AW = $clog2(DEPTH);
  w_entry_t mem [DEPTH];
  logic [AW:0] wp, rp;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + (AW+1)'(1);
      if (pop) rp <= rp + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= din;
  assign dout = mem[rp[AW-1:0]];
  assign empty = wp == rp;
  assign full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
endmodule

// File: rtl/weight_fetch_ctrl.sv
// weight_fetch_ctrl: fetches one BN word then streams LEN weight vectors through a credit-tracked FIFO.
// Defining WEIGHT_FETCH_PERF_EN adds stall_cnt/issue_cnt counters.
module weight_fetch_ctrl
  import weight_fetch_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W-1:0]    len_m1,
  input  logic [BN_ADDR_W-1:0] bn_addr,
  output logic                 busy,
  output logic                 done,
  output logic [BN_W-1:0]      bn_data,
  output logic                 bn_valid,
`ifdef WEIGHT_FETCH_PERF_EN
  output logic [15:0]          stall_cnt,
  output logic [15:0]          issue_cnt,
`endif
  weight_fetch_ctrl_if.master  bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int LW = $clog2(RD_LAT + 1);
  state_t state, nxt;
  logic [ADDR_W-1:0] base_q, len_q, cnt;
  logic [BN_ADDR_W-1:0] bn_q;
  logic [LW-1:0] lat;
  logic [CW-1:0] credits;
  logic [RD_LAT-1:0] pv, pl;
  logic issue, last_iss, push, pop, full, empty;
  w_entry_t din, head;
  assign issue = state == W_RD && credits != '0;
  assign last_iss = cnt == len_q;
  assign push = pv[RD_LAT-1];
  assign pop = !empty && bus.w_ready;
  assign din = '{last: pl[RD_LAT-1], data: bus.w_rdata};
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = start ? BN_RD : IDLE;
      BN_RD:   nxt = BN_WAIT;
      BN_WAIT: nxt = lat == LW'(RD_LAT - 1) ? W_RD : BN_WAIT;
      W_RD:    nxt = issue && last_iss ? DRAIN : W_RD;
      DRAIN:   nxt = pop && head.last ? IDLE : DRAIN;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      base_q <= '0;
      len_q <= '0;
      bn_q <= '0;
      cnt <= '0;
      lat <= '0;
      credits <= CW'(FIFO_DEPTH);
      pv <= '0;
      pl <= '0;
      bn_data <= '0;
      bn_valid <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= nxt;
      done <= state == DRAIN && nxt == IDLE;
      if (state == IDLE && start) begin
        base_q <= base_addr;
        len_q <= len_m1;
        bn_q <= bn_addr;
        bn_valid <= 1'b0;
        cnt <= '0;
        lat <= '0;
      end
      if (state == BN_WAIT) lat <= lat + LW'(1);
      if (state == BN_WAIT && nxt == W_RD) begin
        bn_data <= bus.bn_rdata;
        bn_valid <= 1'b1;
      end
      if (issue) cnt <= cnt + ADDR_W'(1);
      credits <= credits - CW'(issue) + CW'(pop);
      pv[0] <= issue;
      pl[0] <= issue && last_iss;
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        pl[i] <= pl[i-1];
      end
    end
  weight_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );
  // credits bound in-flight reads plus FIFO occupancy, so a push into a full FIFO is a design bug
  always_ff @(posedge clk)
    if (rst_n) assert (!(push && full));
  assign busy = state != IDLE;
  assign bus.w_valid = !empty;
  assign bus.w_data = empty ? '0 : head.data;
  assign bus.w_last = !empty && head.last;
  assign bus.w_cs = issue;
  assign bus.w_oe = issue;
  assign bus.w_addr = issue ? base_q + cnt : '0;
  assign bus.bn_cs = state == BN_RD;
  assign bus.bn_oe = state == BN_RD;
  assign bus.bn_addr_o = state == BN_RD ? bn_q : '0;
  assign bus.sram_we = '0;
`ifdef WEIGHT_FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_cnt <= '0;
      issue_cnt <= '0;
    end else if (state == IDLE && start) begin
      stall_cnt <= '0;
      issue_cnt <= '0;
    end else begin
      if (state == W_RD && credits == '0 && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (issue && issue_cnt != 16'hFFFF) issue_cnt <= issue_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// tb_weight_fetch_ctrl: drives RD_LAT=1 and RD_LAT=3 controllers with identical jobs against SRAM models and a scoreboard
module tb_weight_fetch_ctrl;
  import weight_fetch_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, w_ready = 1'b1;
  logic [8:0] base_addr = '0, len_m1 = '0;
  logic [6:0] bn_addr = '0;
  logic busy_a, done_a, bn_valid_a, busy_b, done_b, bn_valid_b;
  logic [15:0] bn_data_a, bn_data_b, exp_bn;
  int errors = 0, checks = 0, cyc = 0;
  int first_hs[2], last_hs[2], first_iss[2], first_v[2], done_c[2];
  int done_n[2] = '{0, 0};
  int outst[2] = '{0, 0};
  logic [8:0] aq0[$], aq1[$], dq0[$], dq1[$];
  logic [8:0] wa_a, wa_b[3];
  logic [6:0] na_a, na_b[3];
  weight_fetch_ctrl_if ba();
  weight_fetch_ctrl_if bb();
  weight_fetch_ctrl #(.RD_LAT(1), .FIFO_DEPTH(4)) ua (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len_m1(len_m1), .bn_addr(bn_addr),
    .busy(busy_a), .done(done_a), .bn_data(bn_data_a), .bn_valid(bn_valid_a), .bus(ba)
  );
  weight_fetch_ctrl #(.RD_LAT(3), .FIFO_DEPTH(4)) ub (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len_m1(len_m1), .bn_addr(bn_addr),
    .busy(busy_b), .done(done_b), .bn_data(bn_data_b), .bn_valid(bn_valid_b), .bus(bb)
  );
  function automatic logic [7:0] wmem(input logic [8:0] a);
    return a[7:0] ^ (a[8] ? 8'hA5 : 8'h3C);
  endfunction
  function automatic logic [15:0] bmem(input logic [6:0] a);
    return a == 7'h05 ? 16'hBEEF : {9'h15A, a};
  endfunction
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    wa_a <= ba.w_addr;
    na_a <= ba.bn_addr_o;
    wa_b[0] <= bb.w_addr;
    wa_b[1] <= wa_b[0];
    wa_b[2] <= wa_b[1];
    na_b[0] <= bb.bn_addr_o;
    na_b[1] <= na_b[0];
    na_b[2] <= na_b[1];
  end
  assign ba.w_ready = w_ready;
  assign bb.w_ready = w_ready;
  assign ba.w_rdata = wmem(wa_a);
  assign bb.w_rdata = wmem(wa_b[2]);
  assign ba.bn_rdata = bmem(na_a);
  assign bb.bn_rdata = bmem(na_b[2]);
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic observe(input int k, input logic v, l, cs, oe, bcs, dn, bz, bv,
                         input logic [7:0] d, input logic [8:0] a, we, input logic [15:0] bd);
    logic [8:0] e;
    logic hs;
    int n;
    hs = v && w_ready;
    check("sram_we", 64'(we), 64'(0));
    check("cs_excl", 64'(cs & bcs), 64'(0));
    check("oe_eq_cs", 64'(oe), 64'(cs));
    if (cs) begin
      check("credit_gate", 64'(outst[k] < 4), 64'(1));
      if (first_iss[k] < 0) first_iss[k] = cyc;
      n = k == 0 ? aq0.size() : aq1.size();
      if (n == 0) check("extra_issue", 64'(a), 64'(0));
      else begin
        if (k == 0) e = aq0.pop_front();
        else e = aq1.pop_front();
        check("issue_addr", 64'(a), 64'(e));
      end
    end
    if (v && first_v[k] < 0) first_v[k] = cyc;
    if (hs) begin
      if (first_hs[k] < 0) begin
        first_hs[k] = cyc;
        check("bn_before_w", 64'({bv, bd}), 64'({1'b1, exp_bn}));
      end
      last_hs[k] = cyc;
      n = k == 0 ? dq0.size() : dq1.size();
      if (n == 0) check("extra_word", 64'({l, d}), 64'(0));
      else begin
        if (k == 0) e = dq0.pop_front();
        else e = dq1.pop_front();
        check("word", 64'({l, d}), 64'(e));
      end
    end
    if (dn) begin
      done_n[k]++;
      done_c[k] = cyc;
      check("busy_at_done", 64'(bz), 64'(0));
    end
    outst[k] += int'(cs) - int'(hs);
    check("outstanding", 64'(outst[k] >= 0 && outst[k] <= 4), 64'(1));
  endtask
  always @(negedge clk) begin
    observe(0, ba.w_valid, ba.w_last, ba.w_cs, ba.w_oe, ba.bn_cs, done_a, busy_a, bn_valid_a,
            ba.w_data, ba.w_addr, ba.sram_we, bn_data_a);
    observe(1, bb.w_valid, bb.w_last, bb.w_cs, bb.w_oe, bb.bn_cs, done_b, busy_b, bn_valid_b,
            bb.w_data, bb.w_addr, bb.sram_we, bn_data_b);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic rst_zero(input string tag);
    check(tag, 64'({busy_a, done_a, bn_valid_a, bn_data_a, ba.w_valid, ba.w_data, ba.w_last, ba.w_cs,
                    ba.w_oe, ba.w_addr, ba.bn_cs, ba.bn_oe, ba.bn_addr_o, ba.sram_we}), 64'(0));
    check(tag, 64'({busy_b, done_b, bn_valid_b, bn_data_b, bb.w_valid, bb.w_data, bb.w_last, bb.w_cs,
                    bb.w_oe, bb.w_addr, bb.bn_cs, bb.bn_oe, bb.bn_addr_o, bb.sram_we}), 64'(0));
  endtask
  task automatic kick(input logic [8:0] base, input logic [8:0] len, input logic [6:0] bn);
    logic [8:0] a;
    for (int i = 0; i <= int'(len); i++) begin
      a = base + 9'(i);
      aq0.push_back(a);
      aq1.push_back(a);
      dq0.push_back({i == int'(len), wmem(a)});
      dq1.push_back({i == int'(len), wmem(a)});
    end
    exp_bn = bmem(bn);
    for (int k = 0; k < 2; k++) begin
      first_hs[k] = -1;
      last_hs[k] = -1;
      first_iss[k] = -1;
      first_v[k] = -1;
      done_c[k] = -1;
      done_n[k] = 0;
    end
    step();
    start = 1'b1;
    base_addr = base;
    len_m1 = len;
    bn_addr = bn;
    step();
    start = 1'b0;
    check("busy_start", 64'({busy_a, busy_b}), 64'(2'b11));
    check("bn_clear", 64'({bn_valid_a, bn_valid_b}), 64'(0));
  endtask
  task automatic finish_job(input int len, input bit rnd, input bit restart);
    int n, lat;
    n = 0;
    while (!(done_n[0] > 0 && done_n[1] > 0) && n < 400) begin
      step();
      n++;
      if (rnd) w_ready = 1'($urandom_range(0, 1));
      start = restart && n == 4;
      if (start) begin
        base_addr = 9'h0AA;
        len_m1 = 9'd2;
        bn_addr = 7'h11;
      end
    end
    check("job_timeout", 64'(n < 400), 64'(1));
    start = 1'b0;
    w_ready = 1'b1;
    repeat (4) step();
    check("busy_idle", 64'({busy_a, busy_b}), 64'(0));
    check("bn_hold_a", 64'({bn_valid_a, bn_data_a}), 64'({1'b1, exp_bn}));
    check("bn_hold_b", 64'({bn_valid_b, bn_data_b}), 64'({1'b1, exp_bn}));
    check("left_a", 64'(aq0.size() + dq0.size()), 64'(0));
    check("left_b", 64'(aq1.size() + dq1.size()), 64'(0));
    for (int k = 0; k < 2; k++) begin
      lat = k == 0 ? 1 : 3;
      check("done_once", 64'(done_n[k]), 64'(1));
      check("first_valid_lat", 64'(first_v[k] - first_iss[k]), 64'(lat + 1));
      check("done_after_last", 64'(done_c[k] - last_hs[k]), 64'(1));
    end
    if (!rnd) check("back_to_back", 64'(last_hs[0] - first_hs[0]), 64'(len));
  endtask
  initial begin
    repeat (2) step();
    rst_zero("reset_state");
    rst_n = 1'b1;
    kick(9'h010, 9'd3, 7'h05);
    finish_job(3, 1'b0, 1'b0);
    kick(9'h1FE, 9'd3, 7'h12);
    finish_job(3, 1'b0, 1'b0);
    kick(9'h040, 9'd15, 7'h33);
    finish_job(15, 1'b1, 1'b0);
    kick(9'h100, 9'd7, 7'h05);
    finish_job(7, 1'b0, 1'b1);
    kick(9'h080, 9'd15, 7'h05);
    w_ready = 1'b0;
    repeat (7) step();
    check("busy_mid", 64'({busy_a, busy_b}), 64'(2'b11));
    check("valid_mid", 64'(ba.w_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1 rst_zero("rst_async");
    aq0.delete();
    aq1.delete();
    dq0.delete();
    dq1.delete();
    outst = '{0, 0};
    repeat (2) step();
    rst_n = 1'b1;
    check("no_done_abort", 64'(done_n[0] + done_n[1]), 64'(0));
    w_ready = 1'b1;
    kick(9'h0C0, 9'd5, 7'h05);
    finish_job(5, 1'b0, 1'b0);
    kick(9'h123, 9'd0, 7'h7F);
    finish_job(0, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
